// File: rtl/imu_spi_seq.sv
// imu_spi_seq: sequences a 16-bit SPI monarch to bring up an inertial sensor
// and stream yaw-rate samples.
//
// Flow: wait INIT_DLY clocks after reset, issue three configuration writes,
// then service sensor data-ready interrupts. Each interrupt becomes a two
// transaction read (low byte, then high byte), assembled into yaw_rt with a
// single-cycle vld strobe.
//
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   INT      in   sensor data-ready, asynchronous to clk
//   done     in   SPI transaction complete (1-cycle pulse)
//   rd_data  in   SPI read data, valid with done
//   wrt      out  1-cycle SPI start pulse
//   cmd      out  SPI write word, stable from wrt until done
//   yaw_rt   out  signed yaw rate {high byte, low byte}
//   vld      out  1-cycle strobe, yaw_rt updated in the same cycle
//
// Optional build macro YAW_AVG_EN: yaw_rt becomes the mean of the last four
// assembled samples and vld stays quiet until four samples exist.
//
// wrt/cmd/yaw_rt/vld are Mealy outputs: they respond in the cycle done (or
// the start condition) is seen, so there is no extra pipeline stage between
// a done and the next wrt, or between the final done and vld.

module imu_spi_seq #(
    parameter logic [15:0] INIT_DLY = 16'hFFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld
);

    localparam logic [15:0] CMD_CFG1 = 16'h0D02;
    localparam logic [15:0] CMD_CFG2 = 16'h1160;
    localparam logic [15:0] CMD_CFG3 = 16'h1440;
    localparam logic [15:0] CMD_RDL  = 16'hA600;
    localparam logic [15:0] CMD_RDH  = 16'hA700;

    typedef enum logic [2:0] {
        INIT,
        CFG1,
        CFG2,
        CFG3,
        IDLE,
        RD_L,
        RD_H
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic        pending_q, pending_d;
    logic        int_ff1_q, int_ff1_d;
    logic        int_ff2_q, int_ff2_d;
    logic        int_ff3_q, int_ff3_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] cmd_q, cmd_d;
    logic [15:0] yaw_rt_q, yaw_rt_d;

    logic        int_rise;
    logic        rd_l_issue;
    logic        sample_stb;
    logic [15:0] sample;

    // Only the low byte of each SPI read carries sensor data.
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[15:8];

`ifdef YAW_AVG_EN
    // The newest of the four averaged samples comes straight off rd_data,
    // so only the three prior samples are stored.
    logic [2:0][15:0]   hist_q, hist_d;
    logic [1:0]         fill_q, fill_d;
    logic signed [17:0] sum;

    function automatic logic signed [17:0] sx(input logic [15:0] v);
        return {{2{v[15]}}, v};
    endfunction
`endif

    assign int_rise = int_ff2_q & ~int_ff3_q;
    assign sample   = {rd_data[7:0], lo_q};

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        lo_d       = lo_q;
        cmd_d      = cmd_q;
        yaw_rt_d   = yaw_rt_q;
        wrt        = 1'b0;
        vld        = 1'b0;
        rd_l_issue = 1'b0;
        sample_stb = 1'b0;
        int_ff1_d  = INT;
        int_ff2_d  = int_ff1_q;
        int_ff3_d  = int_ff2_q;
`ifdef YAW_AVG_EN
        hist_d     = hist_q;
        fill_d     = fill_q;
        sum        = sx(sample) + sx(hist_q[0]) + sx(hist_q[1]) + sx(hist_q[2]);
`endif

        case (state_q)
            INIT: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == INIT_DLY) begin
                    wrt     = 1'b1;
                    cmd_d   = CMD_CFG1;
                    state_d = CFG1;
                end
            end
            CFG1: begin
                if (done) begin
                    wrt     = 1'b1;
                    cmd_d   = CMD_CFG2;
                    state_d = CFG2;
                end
            end
            CFG2: begin
                if (done) begin
                    wrt     = 1'b1;
                    cmd_d   = CMD_CFG3;
                    state_d = CFG3;
                end
            end
            CFG3: begin
                if (done) state_d = IDLE;
            end
            IDLE: begin
                if (pending_q) begin
                    wrt        = 1'b1;
                    cmd_d      = CMD_RDL;
                    rd_l_issue = 1'b1;
                    state_d    = RD_L;
                end
            end
            RD_L: begin
                if (done) begin
                    lo_d    = rd_data[7:0];
                    wrt     = 1'b1;
                    cmd_d   = CMD_RDH;
                    state_d = RD_H;
                end
            end
            RD_H: begin
                if (done) begin
                    sample_stb = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: state_d = INIT;
        endcase

        if (sample_stb) begin
`ifdef YAW_AVG_EN
            hist_d = {hist_q[1], hist_q[0], sample};
            if (fill_q == 2'd3) begin
                yaw_rt_d = 16'(sum >>> 2);
                vld      = 1'b1;
            end else begin
                fill_d = fill_q + 2'd1;
            end
`else
            yaw_rt_d = sample;
            vld      = 1'b1;
`endif
        end

        // A newly arriving edge beats the clear from the RD_L issue.
        pending_d = int_rise | (pending_q & ~rd_l_issue);

        // No transaction start or strobe leaks out while reset is held.
        if (rst) begin
            wrt = 1'b0;
            vld = 1'b0;
        end
    end

    assign cmd    = cmd_d;
    assign yaw_rt = yaw_rt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            timer_q   <= 16'h0000;
            pending_q <= 1'b0;
            int_ff1_q <= 1'b0;
            int_ff2_q <= 1'b0;
            int_ff3_q <= 1'b0;
            lo_q      <= 8'h00;
            cmd_q     <= 16'h0000;
            yaw_rt_q  <= 16'h0000;
`ifdef YAW_AVG_EN
            hist_q    <= '0;
            fill_q    <= 2'd0;
`endif
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pending_q <= pending_d;
            int_ff1_q <= int_ff1_d;
            int_ff2_q <= int_ff2_d;
            int_ff3_q <= int_ff3_d;
            lo_q      <= lo_d;
            cmd_q     <= cmd_d;
            yaw_rt_q  <= yaw_rt_d;
`ifdef YAW_AVG_EN
            hist_q    <= hist_d;
            fill_q    <= fill_d;
`endif
        end
    end

endmodule
